reservation_station_multi: RTL

RESERVATION_STATION_MULTI -- requirements
Module: reservation_station_multi

---
 rtl/rs_pkg.sv | 31 +++
 rtl/rs_age_select.sv | 47 ++++
 rtl/reservation_station_multi.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// rs_pkg: shared types for the reservation station.
//   rs_entry_t : one RS slot (valid, destination tag, command, two source
//                operands each held as producer tag + value).
//   rs_opnd_t  : a single source operand (tag + value).
//   TAG_NONE   : tag value meaning "no producer, value is final".
// Field widths are sized to the largest supported parameters; the station
// zero-extends narrower tags/values into them and truncates on the way out.
package rs_pkg;

  localparam int RS_TAG_MAX  = 16;
  localparam int RS_CMD_MAX  = 32;
  localparam int RS_DATA_MAX = 128;

  localparam logic [RS_TAG_MAX-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic [RS_TAG_MAX-1:0]  tag;
    logic [RS_DATA_MAX-1:0] val;
  } rs_opnd_t;

  typedef struct packed {
    logic                   valid;
    logic [RS_TAG_MAX-1:0]  tag;
    logic [RS_CMD_MAX-1:0]  cmd;
    logic [RS_TAG_MAX-1:0]  src1_tag;
    logic [RS_TAG_MAX-1:0]  src2_tag;
    logic [RS_DATA_MAX-1:0] src1_val;
    logic [RS_DATA_MAX-1:0] src2_val;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: oldest-ready picker built on an age matrix.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   alloc_oh       : one-hot (or zero) slot being allocated this cycle
//   rdy            : per-slot ready flags
//   sel            : one-hot oldest ready slot (zero when none ready)
//   any            : at least one slot is ready
module rs_age_select #(
  parameter int ENTRIES = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [ENTRIES-1:0] alloc_oh,
  input  logic [ENTRIES-1:0] rdy,
  output logic [ENTRIES-1:0] sel,
  output logic               any
);

  // older_q[i][j] = 1 : slot i was allocated before slot j.
  // A new allocation becomes younger than every other slot. Relations with
  // stale (invalid) slots are harmless because those slots are never ready.
  logic [ENTRIES-1:0] older_q [ENTRIES];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        for (int j = 0; j < ENTRIES; j++) begin
          if (alloc_oh[i])      older_q[i][j] <= 1'b0;
          else if (alloc_oh[j]) older_q[i][j] <= 1'b1;
        end
      end
    end
  end

  // The diagonal is always 0, so including j == i needs no special case.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      sel[i] = rdy[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (rdy[j] && older_q[j][i]) sel[i] = 1'b0;
      end
    end
    any = |rdy;
  end

endmodule

// File: rtl/reservation_station_multi.sv
// reservation_station_multi: multi-entry reservation station with result
// forwarding and oldest-ready issue.
//   clk_i, reset_i        : clock, asynchronous active-high reset
//   flush_i               : drop every entry at the next edge, block alloc/issue
//   alloc_*               : decode-side allocation handshake and operands
//   fwd_valid/tag/val_i   : FWD_PORTS result buses, port 0 wins on tag clash
//   issue_*               : functional-unit handshake and selected operands
//   count_o               : occupied entries
// Build option: define RS_FWD_BYPASS_EN to let an entry issue in the same
// cycle its last operand is forwarded (value taken straight from the bus).
// Without it the entry issues one cycle later from stored values.
module reservation_station_multi
  import rs_pkg::*;
#(
  parameter int ENTRIES   = 4,
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 5,
  parameter int CMD_W     = 10,
  parameter int FWD_PORTS = 3
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          flush_i,
  input  logic                          alloc_valid_i,
  output logic                          alloc_ready_o,
  input  logic [TAG_W-1:0]              alloc_tag_i,
  input  logic [CMD_W-1:0]              alloc_cmd_i,
  input  logic [TAG_W-1:0]              alloc_src1_tag_i,
  input  logic [TAG_W-1:0]              alloc_src2_tag_i,
  input  logic                          alloc_src1_rdy_i,
  input  logic                          alloc_src2_rdy_i,
  input  logic [DATA_W-1:0]             alloc_src1_val_i,
  input  logic [DATA_W-1:0]             alloc_src2_val_i,
  input  logic [FWD_PORTS-1:0]          fwd_valid_i,
  input  logic [FWD_PORTS*TAG_W-1:0]    fwd_tag_i,
  input  logic [FWD_PORTS*DATA_W-1:0]   fwd_val_i,
  output logic                          issue_valid_o,
  input  logic                          issue_ready_i,
  output logic [DATA_W-1:0]             issue_val1_o,
  output logic [DATA_W-1:0]             issue_val2_o,
  output logic [CMD_W-1:0]              issue_cmd_o,
  output logic [TAG_W-1:0]              issue_tag_o,
  output logic [$clog2(ENTRIES+1)-1:0]  count_o
);

  localparam int CNT_W = $clog2(ENTRIES + 1);

  rs_entry_t ent_q [ENTRIES];
  rs_entry_t ent_d [ENTRIES];
  rs_entry_t snp   [ENTRIES];   // entry state after this cycle's forwards
  rs_entry_t new_ent;

  logic [ENTRIES-1:0] rdy, sel, alloc_oh, alloc_we;
  logic               sel_any, alloc_fire, issue_fire;
  logic [CNT_W-1:0]   cnt;

  // Replace a pending operand with the forwarded value; scanning from the
  // highest port down lets port 0 have the final word.
  function automatic rs_opnd_t snoop(input rs_opnd_t                     o,
                                     input logic [FWD_PORTS-1:0]        fv,
                                     input logic [FWD_PORTS*TAG_W-1:0]  ft,
                                     input logic [FWD_PORTS*DATA_W-1:0] fd);
    rs_opnd_t r;
    r = o;
    for (int p = FWD_PORTS - 1; p >= 0; p--) begin
      if (fv[p] && o.tag != TAG_NONE && o.tag == RS_TAG_MAX'(ft[p*TAG_W +: TAG_W])) begin
        r.tag = TAG_NONE;
        r.val = RS_DATA_MAX'(fd[p*DATA_W +: DATA_W]);
      end
    end
    return r;
  endfunction

  always_comb begin
    cnt = '0;
    for (int i = 0; i < ENTRIES; i++) cnt = cnt + CNT_W'(ent_q[i].valid);
  end

  assign count_o       = cnt;
  assign alloc_ready_o = (cnt < CNT_W'(ENTRIES));
  assign alloc_fire    = alloc_valid_i & alloc_ready_o & ~flush_i;

  // Lowest-index free slot, taken from registered state only, so a slot
  // freed by this cycle's issue cannot be reused until the next cycle.
  always_comb begin
    alloc_oh = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
      end
    end
  end

  assign alloc_we = alloc_oh & {ENTRIES{alloc_fire}};

  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.tag   = RS_TAG_MAX'(alloc_tag_i);
    new_ent.cmd   = RS_CMD_MAX'(alloc_cmd_i);
    {new_ent.src1_tag, new_ent.src1_val} =
      snoop({alloc_src1_rdy_i ? TAG_NONE : RS_TAG_MAX'(alloc_src1_tag_i),
             RS_DATA_MAX'(alloc_src1_val_i)}, fwd_valid_i, fwd_tag_i, fwd_val_i);
    {new_ent.src2_tag, new_ent.src2_val} =
      snoop({alloc_src2_rdy_i ? TAG_NONE : RS_TAG_MAX'(alloc_src2_tag_i),
             RS_DATA_MAX'(alloc_src2_val_i)}, fwd_valid_i, fwd_tag_i, fwd_val_i);
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      snp[i] = ent_q[i];
      {snp[i].src1_tag, snp[i].src1_val} =
        snoop({ent_q[i].src1_tag, ent_q[i].src1_val}, fwd_valid_i, fwd_tag_i, fwd_val_i);
      {snp[i].src2_tag, snp[i].src2_val} =
        snoop({ent_q[i].src2_tag, ent_q[i].src2_val}, fwd_valid_i, fwd_tag_i, fwd_val_i);
`ifdef RS_FWD_BYPASS_EN
      rdy[i] = snp[i].valid && (snp[i].src1_tag == TAG_NONE) && (snp[i].src2_tag == TAG_NONE);
`else
      rdy[i] = ent_q[i].valid && (ent_q[i].src1_tag == TAG_NONE) && (ent_q[i].src2_tag == TAG_NONE);
`endif
    end
  end

  rs_age_select #(
    .ENTRIES (ENTRIES)
  ) u_age_select (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .alloc_oh (alloc_we),
    .rdy      (rdy),
    .sel      (sel),
    .any      (sel_any)
  );

  assign issue_valid_o = sel_any & ~flush_i;
  assign issue_fire    = issue_valid_o & issue_ready_i;

  // Operands come from the snooped view: for a stored-ready entry it equals
  // the registered value, and with bypass it carries the forwarded value.
  always_comb begin
    issue_val1_o = '0;
    issue_val2_o = '0;
    issue_cmd_o  = '0;
    issue_tag_o  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (sel[i]) begin
        issue_val1_o = DATA_W'(snp[i].src1_val);
        issue_val2_o = DATA_W'(snp[i].src2_val);
        issue_cmd_o  = CMD_W'(snp[i].cmd);
        issue_tag_o  = TAG_W'(snp[i].tag);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ent_d[i] = snp[i];
      if (issue_fire && sel[i]) ent_d[i].valid = 1'b0;
      if (alloc_we[i])          ent_d[i] = new_ent;
      if (flush_i)              ent_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule
